// File: rtl/sme_feeder_pkg.sv
// Shared definitions for the string-matching-engine feeder and matcher.
package sme_feeder_pkg;

  localparam logic [7:0]  LINE_TERM   = 8'h0A;
  localparam int unsigned STR_MAX_DEF = 32;
  localparam int unsigned PAT_MAX_DEF = 8;

  typedef enum logic [2:0] {
    COL_STR  = 3'd0,
    COL_PAT  = 3'd1,
    SEND_STR = 3'd2,
    SEND_PAT = 3'd3,
    WAIT_RES = 3'd4
  } feeder_state_e;

endpackage

// File: rtl/sme_line_buf.sv
// One-line byte buffer: appends bytes, latches the line length at the terminator,
// and offers an asynchronous read port for replay.
module sme_line_buf #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          line_end,
  input  logic                          clr,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] rd_addr,
  output logic [7:0]                    rd_data,
  output logic [$clog2(DEPTH + 1)-1:0]  len,
  output logic                          empty,
  output logic                          ovf
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [7:0]    mem_q [DEPTH];
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] len_q, len_d;
  logic          mem_we;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    len_d    = len_q;
    mem_we   = 1'b0;
    ovf      = 1'b0;
    if (clr) begin
      wr_ptr_d = '0;
      len_d    = '0;
    end else if (line_end) begin
      len_d    = wr_ptr_q;
      wr_ptr_d = '0;
    end else if (wr_en) begin
      // Bytes past the end are dropped; the line keeps its full-buffer length.
      if (wr_ptr_q < LW'(DEPTH)) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + LW'(1);
      end else begin
        ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      len_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      len_q    <= len_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];
  assign len     = len_q;
  assign empty   = (wr_ptr_q == '0);

endmodule

// File: rtl/sme_feeder.sv
// Collects string/pattern lines from a byte stream, replays them to the matcher
// as contiguous bursts, and returns one result per pattern.
module sme_feeder
  import sme_feeder_pkg::*;
#(
  parameter int unsigned STR_MAX  = STR_MAX_DEF,
  parameter int unsigned PAT_MAX  = PAT_MAX_DEF,
  parameter int unsigned WD_LIMIT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic [7:0] res_id,
  output logic       err_ovf,
  output logic       err_wd
);

  localparam int unsigned SAW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
  localparam int unsigned PAW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
  localparam int unsigned SLW = $clog2(STR_MAX + 1);
  localparam int unsigned PLW = $clog2(PAT_MAX + 1);
  localparam int unsigned CW  = (SLW > PLW) ? SLW : PLW;
  localparam int unsigned WW  = $clog2(WD_LIMIT + 1);

  feeder_state_e state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          first_q, first_d;
  logic [7:0]    chardata_q, chardata_d;
  logic          isstring_q, isstring_d, ispattern_q, ispattern_d;
  logic          res_valid_q, res_valid_d, res_match_q, res_match_d;
  logic [4:0]    res_index_q, res_index_d;
  logic [7:0]    res_id_q, res_id_d;
  logic          err_ovf_q, err_ovf_d, err_wd_q, err_wd_d;

  logic           str_wr, str_end, str_clr, str_empty, str_ovf;
  logic           pat_wr, pat_end, pat_empty, pat_ovf;
  logic [7:0]     str_rd_data, pat_rd_data;
  logic [SLW-1:0] str_len;
  logic [PLW-1:0] pat_len;
  logic [CW-1:0]  str_len_w, pat_len_w;
  logic           acc, is_term;

  sme_line_buf #(.DEPTH(STR_MAX)) u_str_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (str_wr),
    .wr_data  (in_data),
    .line_end (str_end),
    .clr      (str_clr),
    .rd_addr  (idx_q[SAW-1:0]),
    .rd_data  (str_rd_data),
    .len      (str_len),
    .empty    (str_empty),
    .ovf      (str_ovf)
  );

  sme_line_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (pat_wr),
    .wr_data  (in_data),
    .line_end (pat_end),
    .clr      (1'b0),
    .rd_addr  (idx_q[PAW-1:0]),
    .rd_data  (pat_rd_data),
    .len      (pat_len),
    .empty    (pat_empty),
    .ovf      (pat_ovf)
  );

  assign in_ready  = (state_q == COL_STR) || (state_q == COL_PAT);
  assign acc       = in_valid && in_ready;
  assign is_term   = (in_data == LINE_TERM);
  assign str_len_w = CW'(str_len);
  assign pat_len_w = CW'(pat_len);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wd_d        = wd_q;
    first_d     = first_q;
    chardata_d  = '0;
    isstring_d  = 1'b0;
    ispattern_d = 1'b0;
    res_valid_d = 1'b0;
    res_match_d = res_match_q;
    res_index_d = res_index_q;
    // res_id holds its value through the result pulse and advances afterwards.
    res_id_d    = res_valid_q ? res_id_q + 8'd1 : res_id_q;
    err_ovf_d   = err_ovf_q | str_ovf | pat_ovf;
    err_wd_d    = err_wd_q;
    str_wr      = 1'b0;
    str_end     = 1'b0;
    str_clr     = 1'b0;
    pat_wr      = 1'b0;
    pat_end     = 1'b0;
    case (state_q)
      COL_STR: begin
        if (acc) begin
          if (!is_term) begin
            str_wr = 1'b1;
          end else if (!str_empty) begin
            str_end  = 1'b1;
            first_d  = 1'b1;
            res_id_d = '0;
            state_d  = COL_PAT;
          end
        end
      end
      COL_PAT: begin
        if (acc) begin
          if (!is_term) begin
            pat_wr = 1'b1;
          end else if (pat_empty) begin
            str_clr = 1'b1;
            state_d = COL_STR;
          end else begin
            pat_end = 1'b1;
            idx_d   = '0;
            state_d = first_q ? SEND_STR : SEND_PAT;
          end
        end
      end
      SEND_STR: begin
        isstring_d = 1'b1;
        chardata_d = str_rd_data;
        if (idx_q == str_len_w - CW'(1)) begin
          idx_d   = '0;
          state_d = SEND_PAT;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      SEND_PAT: begin
        ispattern_d = 1'b1;
        chardata_d  = pat_rd_data;
        if (idx_q == pat_len_w - CW'(1)) begin
          idx_d   = '0;
          wd_d    = '0;
          first_d = 1'b0;
          state_d = WAIT_RES;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      WAIT_RES: begin
        if (sme_valid) begin
          res_valid_d = 1'b1;
          res_match_d = sme_match;
          res_index_d = sme_index;
          state_d     = COL_PAT;
        end else if (wd_q == WW'(WD_LIMIT - 1)) begin
          err_wd_d    = 1'b1;
          res_valid_d = 1'b1;
          res_match_d = 1'b0;
          res_index_d = '0;
          state_d     = COL_PAT;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      default: state_d = COL_STR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= COL_STR;
      idx_q       <= '0;
      wd_q        <= '0;
      first_q     <= 1'b0;
      chardata_q  <= '0;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_match_q <= 1'b0;
      res_index_q <= '0;
      res_id_q    <= '0;
      err_ovf_q   <= 1'b0;
      err_wd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wd_q        <= wd_d;
      first_q     <= first_d;
      chardata_q  <= chardata_d;
      isstring_q  <= isstring_d;
      ispattern_q <= ispattern_d;
      res_valid_q <= res_valid_d;
      res_match_q <= res_match_d;
      res_index_q <= res_index_d;
      res_id_q    <= res_id_d;
      err_ovf_q   <= err_ovf_d;
      err_wd_q    <= err_wd_d;
    end
  end

  assign chardata  = chardata_q;
  assign isstring  = isstring_q;
  assign ispattern = ispattern_q;
  assign res_valid = res_valid_q;
  assign res_match = res_match_q;
  assign res_index = res_index_q;
  assign res_id    = res_id_q;
  assign err_ovf   = err_ovf_q;
  assign err_wd    = err_wd_q;

endmodule

// File: tb/tb_sme_feeder.sv
// Directed bench for sme_feeder: line grouping, burst replay, results, overflow, watchdog, reset.
module tb_sme_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] chardata;
  logic       isstring, ispattern;
  logic       sme_valid, sme_match;
  logic [4:0] sme_index;
  logic       res_valid, res_match;
  logic [4:0] res_index;
  logic [7:0] res_id;
  logic       err_ovf, err_wd;

  int n_checks = 0;
  int n_pass   = 0;

  sme_feeder #(.STR_MAX(32), .PAT_MAX(8), .WD_LIMIT(255)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .chardata  (chardata),
    .isstring  (isstring),
    .ispattern (ispattern),
    .sme_valid (sme_valid),
    .sme_match (sme_match),
    .sme_index (sme_index),
    .res_valid (res_valid),
    .res_match (res_match),
    .res_index (res_index),
    .res_id    (res_id),
    .err_ovf   (err_ovf),
    .err_wd    (err_wd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 400 && !in_ready; i++) tick();
    if (!in_ready) begin
      n_checks++;
      $display("FAIL in_ready_wait: got in_ready=0 after 400 cycles, required 1");
    end
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    send_byte(8'h0A);
  endtask

  // Call right after the line that triggers a burst; returns on the cycle the burst ends.
  task automatic check_burst(input string es, input string ep);
    logic [7:0] gs[$];
    logic [7:0] gp[$];
    int first_s = -1, last_s = -1, first_p = -1, last_p = -1;
    int bad_ovl = 0, bad_s = 0, bad_p = 0, cyc = 0;
    bit done = 0;
    while (!done && cyc < 100) begin
      tick();
      if (isstring && ispattern) bad_ovl++;
      if (!isstring && !ispattern && chardata !== 8'h00) bad_ovl++;
      if (isstring) begin
        if (first_s < 0) first_s = cyc;
        last_s = cyc;
        gs.push_back(chardata);
      end
      if (ispattern) begin
        if (first_p < 0) first_p = cyc;
        last_p = cyc;
        gp.push_back(chardata);
      end
      if (last_p >= 0 && !ispattern) done = 1;
      cyc++;
    end
    n_checks++;
    if (!done) $display("FAIL burst_end: burst not finished after %0d cycles", cyc);
    else n_pass++;

    if (gs.size() != es.len()) bad_s = 1;
    else for (int i = 0; i < es.len(); i++) if (gs[i] !== es[i]) bad_s++;
    n_checks++;
    if (bad_s != 0) $display("FAIL str_bytes: got %0d bytes (%0d wrong), required %0d bytes", gs.size(), bad_s, es.len());
    else n_pass++;

    if (gp.size() != ep.len()) bad_p = 1;
    else for (int i = 0; i < ep.len(); i++) if (gp[i] !== ep[i]) bad_p++;
    n_checks++;
    if (bad_p != 0) $display("FAIL pat_bytes: got %0d bytes (%0d wrong), required %0d bytes", gp.size(), bad_p, ep.len());
    else n_pass++;

    n_checks++;
    if (first_p !== es.len() || last_p !== es.len() + ep.len() - 1 ||
        (es.len() > 0 && (first_s !== 0 || last_s !== es.len() - 1)))
      $display("FAIL burst_timing: got str %0d..%0d pat %0d..%0d, required str 0..%0d pat %0d..%0d",
               first_s, last_s, first_p, last_p, es.len() - 1, es.len(), es.len() + ep.len() - 1);
    else n_pass++;

    n_checks++;
    if (bad_ovl != 0) $display("FAIL strobe_exclusive: got %0d bad cycles, required 0", bad_ovl);
    else n_pass++;
  endtask

  task automatic give_result(input logic m, input logic [4:0] idx, input logic [7:0] exp_id);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL wait_ready: got in_ready=%0b, required 0", in_ready);
    else n_pass++;
    sme_valid = 1'b1;
    sme_match = m;
    sme_index = idx;
    tick();
    sme_valid = 1'b0;
    sme_match = 1'b0;
    sme_index = '0;
    n_checks++;
    if ({res_valid, res_match, res_index, res_id} !== {1'b1, m, idx, exp_id})
      $display("FAIL result: got valid=%0b match=%0b index=%0d id=%0d, required 1 %0b %0d %0d",
               res_valid, res_match, res_index, res_id, m, idx, exp_id);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL back_to_col_pat: got in_ready=%0b, required 1", in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (res_valid !== 1'b0) $display("FAIL res_pulse: got res_valid=%0b on 2nd cycle, required 0", res_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [26:0] obs;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h41;
    sme_valid = 1'b1;
    sme_match = 1'b1;
    sme_index = 5'd7;
    tick(); tick(); tick();
    in_valid  = 1'b0;
    in_data   = 8'h00;
    sme_valid = 1'b0;
    sme_match = 1'b0;
    sme_index = '0;
    reset     = 1'b0;
    tick();
    obs = {isstring, ispattern, chardata, res_valid, res_match, res_index, res_id, err_ovf, err_wd};
    n_checks++;
    if (obs !== 27'd0) $display("FAIL reset_outputs: got %07h, required 0000000", obs);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready: got %0b, required 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    send_line("abc");
    send_line("b");
    check_burst("abc", "b");
    give_result(1'b1, 5'd1, 8'd0);
  endtask

  task automatic test_second_pattern();
    send_line("cdefghij");
    check_burst("", "cdefghij");
    give_result(1'b0, 5'd5, 8'd1);
    n_checks++;
    if (err_ovf !== 1'b0) $display("FAIL exact_fit_ovf: got err_ovf=%0b, required 0", err_ovf);
    else n_pass++;
  endtask

  task automatic test_ignore_sme_valid();
    sme_valid = 1'b1;
    sme_match = 1'b1;
    sme_index = 5'd9;
    tick();
    sme_valid = 1'b0;
    sme_match = 1'b0;
    sme_index = '0;
    tick();
    n_checks++;
    if ({res_valid, res_index} !== {1'b0, 5'd5})
      $display("FAIL stray_sme_valid: got res_valid=%0b res_index=%0d, required 0 5", res_valid, res_index);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    int cnt = 0;
    send_line("ab");
    check_burst("", "ab");
    n_checks++;
    if (err_wd !== 1'b0) $display("FAIL wd_before: got err_wd=%0b, required 0", err_wd);
    else n_pass++;
    while (!res_valid && cnt < 300) begin
      tick();
      cnt++;
    end
    n_checks++;
    if (cnt !== 254) $display("FAIL wd_delay: got %0d cycles after burst, required 254", cnt);
    else n_pass++;
    n_checks++;
    if ({res_valid, res_match, res_index, res_id, err_wd} !== {1'b1, 1'b0, 5'd0, 8'd2, 1'b1})
      $display("FAIL wd_result: got valid=%0b match=%0b index=%0d id=%0d err_wd=%0b, required 1 0 0 2 1",
               res_valid, res_match, res_index, res_id, err_wd);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL wd_col_pat: got in_ready=%0b, required 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_empty_lines();
    send_line("");
    send_line("");
    send_line("");
    send_line("xy");
    send_line("");
    send_line("pq");
    send_line("p");
    check_burst("pq", "p");
    give_result(1'b1, 5'd3, 8'd0);
  endtask

  task automatic test_overflow();
    send_line("");
    send_line("ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmn");
    n_checks++;
    if (err_ovf !== 1'b1) $display("FAIL ovf_set: got err_ovf=%0b, required 1", err_ovf);
    else n_pass++;
    send_line("z");
    check_burst("ABCDEFGHIJKLMNOPQRSTUVWXYZabcdef", "z");
    give_result(1'b0, 5'd7, 8'd0);
    send_line("");
    send_line("hi");
    send_line("i");
    check_burst("hi", "i");
    give_result(1'b1, 5'd2, 8'd0);
    n_checks++;
    if ({err_ovf, err_wd} !== 2'b11) $display("FAIL sticky_errs: got ovf=%0b wd=%0b, required 1 1", err_ovf, err_wd);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    logic [26:0] obs;
    send_line("");
    send_line("mnop");
    send_line("o");
    tick();
    tick();
    n_checks++;
    if ({isstring, chardata} !== {1'b1, 8'h6E}) $display("FAIL mid_burst: got isstring=%0b char=%02h, required 1 6e", isstring, chardata);
    else n_pass++;
    reset = 1'b1;
    tick();
    obs = {isstring, ispattern, chardata, res_valid, res_match, res_index, res_id, err_ovf, err_wd};
    n_checks++;
    if (obs !== 27'd0) $display("FAIL mid_reset_outputs: got %07h, required 0000000", obs);
    else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++;
    if ({in_ready, isstring, ispattern} !== 3'b100) $display("FAIL mid_reset_state: got ready/str/pat=%03b, required 100", {in_ready, isstring, ispattern});
    else n_pass++;
    send_line("q");
    send_line("r");
    check_burst("q", "r");
    give_result(1'b1, 5'd0, 8'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    sme_valid = 1'b0;
    sme_match = 1'b0;
    sme_index = '0;
    test_reset();
    test_basic();
    test_second_pattern();
    test_ignore_sme_valid();
    test_watchdog();
    test_empty_lines();
    test_overflow();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sme_feeder.md
SME_FEEDER -- requirements
Module: sme_feeder

Interface
REQ-001 Parameter STR_MAX, default 32: maximum string bytes buffered per group.
REQ-002 Parameter PAT_MAX, default 8: maximum pattern bytes buffered per line.
REQ-003 Parameter WD_LIMIT, default 255: cycles allowed between end of burst and sme_valid.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  upstream byte valid.
REQ-007 in_data  in  8  upstream ASCII byte; 0x0A is the line terminator.
REQ-008 in_ready  out  1  byte accepted when in_valid and in_ready are both high.
REQ-009 chardata  out  8  byte presented to the matcher.
REQ-010 isstring  out  1  chardata is a string byte.
REQ-011 ispattern  out  1  chardata is a pattern byte.
REQ-012 sme_valid  in  1  matcher result strobe, one cycle.
REQ-013 sme_match  in  1  matcher match flag, sampled with sme_valid.
REQ-014 sme_index  in  5  matcher match index, sampled with sme_valid.
REQ-015 res_valid  out  1  one-cycle result strobe.
REQ-016 res_match  out  1  match flag for result.
REQ-017 res_index  out  5  match index for result.
REQ-018 res_id  out  8  pattern ordinal within current group.
REQ-019 err_ovf  out  1  sticky: line longer than its buffer.
REQ-020 err_wd  out  1  sticky: watchdog expired.

Function
REQ-021 Input is grouped: first non-empty line is the string; each following non-empty line is a pattern; an empty line (0x0A right after a terminator) ends the group.
REQ-022 States SHALL be COL_STR, COL_PAT, SEND_STR, SEND_PAT, WAIT_RES.
REQ-023 in_ready SHALL be high only in COL_STR and COL_PAT; terminator bytes are consumed, not buffered.
REQ-024 COL_STR: empty lines ignored; non-empty line stored, str_len latched, go COL_PAT, res_id cleared to 0.
REQ-025 COL_PAT: empty line discards the string and returns to COL_STR; non-empty line stored, pat_len latched, then go SEND_STR if first pattern of group, else SEND_PAT.
REQ-026 Bytes beyond STR_MAX/PAT_MAX in a line SHALL be dropped and set err_ovf; line still terminates normally.
REQ-027 SEND_STR: isstring high for exactly str_len consecutive cycles, chardata = string bytes in order.
REQ-028 SEND_PAT SHALL start the cycle immediately after the last isstring cycle (no gap); ispattern high for exactly pat_len consecutive cycles.
REQ-029 isstring and ispattern SHALL never be high together; both low outside SEND states; chardata = 0x00 when neither is high.
REQ-030 WAIT_RES: on sme_valid, register res_match/res_index from sme_match/sme_index, pulse res_valid the next cycle, increment res_id (wraps 255->0), go COL_PAT.
REQ-031 A new burst SHALL NOT begin earlier than the cycle after sme_valid is seen.
REQ-032 If WD_LIMIT cycles elapse in WAIT_RES without sme_valid: set err_wd, pulse res_valid with res_match=0, res_index=0, go COL_PAT.
REQ-033 sme_valid outside WAIT_RES SHALL be ignored.
REQ-034 All outputs SHALL be registered; in_ready may be combinational from state only.

Reset
REQ-035 reset SHALL force COL_STR, clear buffers' lengths, res_id, counters, res_valid, res_match, res_index, isstring, ispattern, chardata, err_ovf, err_wd to 0; in_ready high the cycle after release.
REQ-036 reset mid-burst SHALL drop isstring/ispattern the next edge and discard the group.
REQ-037 err_ovf and err_wd SHALL clear only on reset.

Structure
REQ-038 Shared package SHALL hold the state enumeration, terminator constant 0x0A, and STR_MAX/PAT_MAX defaults used by both feeder and matcher.
REQ-039 One sub-module, sme_line_buf (byte buffer with write pointer, length latch and read port), SHALL be instanced twice (string, pattern).

Verification
REQ-040 "abc\n" "b\n" then sme_valid(match=1,index=1) -> isstring 3 cycles a,b,c, ispattern 1 cycle b next cycle, res_valid with match=1 index=1 id=0.
REQ-041 Group with two patterns -> second burst ispattern only, no isstring, res_id=1.
REQ-042 40-byte string line -> 32 bytes sent, err_ovf=1, next lines handled normally.
REQ-043 No sme_valid for 255 cycles -> err_wd=1, res_valid with match=0, back to COL_PAT.
REQ-044 "\n\n" then "xy\n" "\n" "pq\n" "p\n" -> empty lines ignored, group ended, new string pq sent with pattern p.
REQ-045 reset asserted during SEND_STR -> strobes low next cycle, all outputs zero, COL_STR.
